imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader sitting directly upstream of the single-cycle MIPS32 core's instruction memory. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them sequentially into the instruction-memory write port, and verifies a trailing XOR checksum. It holds the core in reset until a frame loads cleanly. Re-triggering it reloads the program at run time.

## Interface
Parameters:
- DEPTH, 256, instruction-memory capacity in 32-bit words; frames longer than this are rejected.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to clk.
- byte_valid  in  1  source presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts; a byte transfers on a rising edge with valid & ready.
- reload  in  1  single-cycle pulse; restarts loading from the header.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  32  byte address, word-aligned (word_index << 2).
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  active-high hold-in-reset for the core.
- load_done  out  1  frame loaded and checksum matched.
- load_err  out  1  length overflow or checksum mismatch.
- words_loaded  out  16  count of words written in the current frame.

## Operation
- Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes (each word MSB first), then one CSUM byte = XOR of all 4·N data bytes only.
- States: IDLE → HDR_HI → HDR_LO → DATA → CSUM → DONE | ERROR.
- IDLE: entered on reset; advances to HDR_HI unconditionally on the next clock.
- HDR_HI/HDR_LO: latch LEN bytes. After LEN_LO: N = 0 → CSUM; N > DEPTH → ERROR; otherwise → DATA.
- DATA: 2-bit byte counter shifts bytes into the word register and XOR-accumulates them. On the 4th byte, the assembled word is written, word_index increments, and words_loaded increments. After word N−1 → CSUM.
- CSUM: one byte. A match with the accumulator → DONE; a mismatch → ERROR. With N = 0 the expected value is 0x00.
- DONE: load_done = 1, cpu_rst = 0. ERROR: load_err = 1, cpu_rst = 1. Both states are terminal until reload.
- reload in any state aborts the current frame and goes to HDR_HI on the next clock. It clears word_index, words_loaded, the byte counter, the accumulator, load_done and load_err, and sets cpu_rst = 1. Any partial word is discarded, and memory contents already written are not erased.
- byte_ready = 1 only in HDR_HI, HDR_LO, DATA and CSUM. byte_valid is ignored in every other state.

## Timing
- Reset values: byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, load_done 0, load_err 0, words_loaded 0; state IDLE.
- byte_ready rises in the first cycle after rst is released (IDLE lasts exactly one cycle).
- All outputs are registered.
- imem_we pulses in the cycle after the edge that accepts the 4th byte of a word; imem_addr and imem_wdata are valid in that same cycle.
- Full throughput: one byte per cycle, no stalls; back-to-back words give imem_we every 4th cycle.
- The last word's imem_we coincides with the first cycle of CSUM.
- DONE/ERROR is entered, and cpu_rst/load_done/load_err update, in the cycle after the CSUM byte is accepted.
- For the overflow case, ERROR is entered in the cycle after LEN_LO is accepted.
- reload takes priority over a simultaneous byte transfer; that byte is not consumed, and byte_ready is deasserted for that edge's effect.
- Arithmetic: word_index and words_loaded are 16-bit and cannot wrap, because N ≤ DEPTH ≤ 65535 is checked. imem_addr is {14'b0, word_index, 2'b00}.

## Structure
- Shared package: state enumeration encoding, and the frame constants (header length 2, bytes per word 4).
- No sub-modules are needed. An optional `byte_to_word` assembler is acceptable as the single natural sub-module: shift register, byte counter and XOR accumulator, with a word_valid output.

## Test plan
- Reset, then frame N=2, words 0x20080005, 0x01094020, CSUM 0x45 → imem_we twice: addr 0x0 data 0x20080005, then addr 0x4 data 0x01094020. Then load_done=1, cpu_rst=0, words_loaded=2.
- Same frame with CSUM 0x00 → both words written, then load_err=1, cpu_rst=1, load_done=0.
- Header N=DEPTH+1 (0x0101) → ERROR the cycle after LEN_LO, no imem_we, byte_ready=0 afterwards.
- N=0, CSUM 0x00 → DONE with words_loaded=0 and no imem_we. N=0 with CSUM 0x01 → ERROR.
- Randomly gate byte_valid during an N=3 frame → identical writes and order to the ungated run; no byte is duplicated or lost.
- reload asserted after 6 data bytes, then a full N=1 frame → no write from the aborted partial word, one write at addr 0x0, DONE. Additionally, assert rst mid-DATA → all outputs return to reset values immediately.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the boot-time instruction-memory loader:
//   - state_t        : loader FSM state encoding (also exposed on dbg_state)
//   - HDR_LEN        : header length in bytes (LEN_HI, LEN_LO)
//   - BYTES_PER_WORD : stream bytes per instruction word
//   - word_addr()    : word index -> word-aligned byte address
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Instruction memory is byte addressed; words sit on 4-byte boundaries.
  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_to_word
//   Assembles big-endian 32-bit words from a byte stream and keeps a running
//   XOR of every byte it has taken.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   i_clear      in   drop any partial word, zero counter and accumulator
//   i_byte_en    in   take i_byte this cycle
//   i_byte       in   stream byte
//   o_word_valid out  i_byte is the 4th byte of a word (combinational)
//   o_word       out  assembled word, valid with o_word_valid (combinational)
//   o_acc        out  XOR of all bytes taken since the last clear (registered)
// -----------------------------------------------------------------------------
module imem_loader_byte_to_word
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  output logic [7:0]  o_acc
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;   // first three bytes of the word, MSB first
  logic [7:0]  r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_acc   <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_acc   <= '0;
    end else if (i_byte_en) begin
      // 2-bit counter wraps back to 0 after the 4th byte of each word.
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {r_shift[15:0], i_byte};
      r_acc   <= r_acc ^ i_byte;
    end
  end

  // The 4th byte is still on the input; the word is completed combinationally
  // so the parent can register the memory write on the accepting edge.
  assign o_word_valid = i_byte_en && (r_cnt == LAST_BYTE);
  assign o_word       = {r_shift, i_byte};
  assign o_acc        = r_acc;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time instruction-memory loader. Receives a framed byte stream
//   (LEN_HI, LEN_LO, 4*N data bytes MSB first, XOR checksum byte), writes the
//   words sequentially into instruction memory and holds the core in reset
//   until a frame has loaded with a matching checksum. reload restarts.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   byte_valid    in   source presents byte_data
//   byte_data     in   stream byte
//   byte_ready    out  loader can take a byte
//   reload        in   single-cycle pulse: abort and restart at the header
//   imem_we       out  one-cycle instruction-memory write strobe
//   imem_addr     out  word-aligned byte address
//   imem_wdata    out  word to write
//   cpu_rst       out  active-high hold-in-reset for the core
//   load_done     out  frame loaded and checksum matched
//   load_err      out  length overflow or checksum mismatch
//   words_loaded  out  words written in the current frame
//   dbg_state     out  current FSM state (state_t encoding)
//
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready
// and reload is low. byte_ready is a registered function of the state (high
// only in HDR_HI, HDR_LO, DATA, CSUM); the source may hold byte_valid high
// for back-to-back transfers at one byte per cycle. A reload on the same edge
// wins: the presented byte is not consumed and must be offered again.
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state
);

  state_t      r_state;
  logic        r_byte_ready;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_cpu_rst;
  logic        r_load_done;
  logic        r_load_err;
  logic [15:0] r_word_index;
  logic [15:0] r_words_loaded;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;

  logic        w_xfer;
  logic        w_data_en;
  logic [15:0] w_len;
  logic        w_len_over;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic [7:0]  w_acc;

  assign w_xfer     = byte_valid && r_byte_ready && !reload;
  assign w_data_en  = w_xfer && (r_state == ST_DATA);
  assign w_len      = {r_len_hi, byte_data};
  assign w_len_over = ({16'd0, w_len} > 32'(DEPTH));

  imem_loader_byte_to_word u_b2w (
    .clk          (clk),
    .rst_n        (rst),
    .i_clear      (reload),
    .i_byte_en    (w_data_en),
    .i_byte       (byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_acc        (w_acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_byte_ready   <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_cpu_rst      <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_err     <= 1'b0;
      r_word_index   <= '0;
      r_words_loaded <= '0;
      r_len_hi       <= '0;
      r_len          <= '0;
    end else if (reload) begin
      // Abort whatever is in flight. Already-written memory stays as is;
      // the partial word is dropped inside the assembler.
      r_state        <= ST_HDR_HI;
      r_byte_ready   <= 1'b1;
      r_imem_we      <= 1'b0;
      r_cpu_rst      <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_err     <= 1'b0;
      r_word_index   <= '0;
      r_words_loaded <= '0;
      r_len_hi       <= '0;
      r_len          <= '0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state      <= ST_HDR_HI;
          r_byte_ready <= 1'b1;
        end

        ST_HDR_HI: begin
          if (w_xfer) begin
            r_len_hi <= byte_data;
            r_state  <= ST_HDR_LO;
          end
        end

        ST_HDR_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
              // Empty program: checksum of zero bytes is 0x00.
              r_state <= ST_CSUM;
            end else if (w_len_over) begin
              r_state      <= ST_ERROR;
              r_byte_ready <= 1'b0;
              r_load_err   <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (w_word_valid) begin
            r_imem_we      <= 1'b1;
            r_imem_addr    <= word_addr(r_word_index);
            r_imem_wdata   <= w_word;
            r_word_index   <= r_word_index + 16'd1;
            r_words_loaded <= r_words_loaded + 16'd1;
            // r_len >= 1 here, so r_len - 1 cannot underflow.
            if (r_word_index == r_len - 16'd1) begin
              r_state <= ST_CSUM;
            end
          end
        end

        ST_CSUM: begin
          if (w_xfer) begin
            r_byte_ready <= 1'b0;
            if (byte_data == w_acc) begin
              r_state     <= ST_DONE;
              r_load_done <= 1'b1;
              r_cpu_rst   <= 1'b0;
            end else begin
              r_state    <= ST_ERROR;
              r_load_err <= 1'b1;
            end
          end
        end

        ST_DONE, ST_ERROR: begin
          // Terminal until reload.
        end

        default: begin
          r_state      <= ST_IDLE;
          r_byte_ready <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready   = r_byte_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign cpu_rst      = r_cpu_rst;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words_loaded;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 256;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];          // {addr, data} of expected writes, in order
  int          cyc = 0;
  int          wr_cyc[$];
  logic [2:0]  last_wr_state;
  logic [31:0] frame_w[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every imem_we must match the head of exp_q.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("wr_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
      wr_cyc.push_back(cyc);
      last_wr_state = dbg_state;
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left just after a rising edge; holds valid until accepted.
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    int tries;
    rdy = 1'b0;
    tries = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!rdy && tries < 40) begin
      rdy = byte_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    byte_valid = 1'b0;
    chk("byte_accept", 64'(rdy), 64'd1);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reload();
    byte_valid = 1'b0;
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  // Sends header, frame_w[0..n-1] and csum; queues the expected writes.
  task automatic send_frame(input logic [15:0] n, input logic [7:0] csum, input bit gated);
    logic [31:0] w;
    for (int i = 0; i < int'(n); i++) exp_q.push_back({32'(i * 4), frame_w[i]});
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      w = frame_w[i];
      for (int b = 0; b < 4; b++) begin
        if (gated) idle($urandom_range(0, 2));
        send_byte(w[8*(3-b) +: 8]);
      end
    end
    if (gated) idle($urandom_range(0, 2));
    send_byte(csum);
  endtask

  task automatic chk_status(input string tag, input logic done, input logic err,
                            input logic crst, input logic [15:0] wl);
    @(negedge clk);
    chk({tag, "_done"}, 64'(load_done), 64'(done));
    chk({tag, "_err"}, 64'(load_err), 64'(err));
    chk({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(crst));
    chk({tag, "_words"}, 64'(words_loaded), 64'(wl));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    chk({tag, "_done"}, 64'(load_done), 64'd0);
    chk({tag, "_err"}, 64'(load_err), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    reload = 1'b0;

    // Reset values, then IDLE lasts exactly one cycle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("idle_ready", 64'(byte_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("hdr_ready", 64'(byte_ready), 64'd1);
    chk("hdr_state", 64'(dbg_state), 64'(ST_HDR_HI));

    // Good N=2 frame, checksum 0x45.
    frame_w[0] = 32'h20080005;
    frame_w[1] = 32'h01094020;
    send_frame(16'd2, 8'h45, 1'b0);
    chk_status("good2", 1'b1, 1'b0, 1'b0, 16'd2);
    chk("good2_state", 64'(dbg_state), 64'(ST_DONE));
    chk("good2_ready", 64'(byte_ready), 64'd0);

    // Reload clears status; same frame with a bad checksum.
    pulse_reload();
    @(negedge clk);
    chk("reload_state", 64'(dbg_state), 64'(ST_HDR_HI));
    chk("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("reload_done", 64'(load_done), 64'd0);
    chk("reload_words", 64'(words_loaded), 64'd0);
    @(posedge clk);
    #1;
    send_frame(16'd2, 8'h00, 1'b0);
    chk_status("badcs", 1'b0, 1'b1, 1'b1, 16'd2);

    // Length overflow: N = DEPTH+1.
    pulse_reload();
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    chk("ovf_state", 64'(dbg_state), 64'(ST_ERROR));
    chk("ovf_err", 64'(load_err), 64'd1);
    chk("ovf_ready", 64'(byte_ready), 64'd0);
    chk("ovf_cpu_rst", 64'(cpu_rst), 64'd1);
    idle(3);
    chk("ovf_pending", 64'(exp_q.size()), 64'd0);

    // Empty frames.
    pulse_reload();
    send_frame(16'd0, 8'h00, 1'b0);
    chk_status("n0_ok", 1'b1, 1'b0, 1'b0, 16'd0);
    pulse_reload();
    send_frame(16'd0, 8'h01, 1'b0);
    chk_status("n0_bad", 1'b0, 1'b1, 1'b1, 16'd0);

    // N=3 at full rate: writes every 4th cycle, last one in CSUM.
    frame_w[0] = 32'h12345678;
    frame_w[1] = 32'h9ABCDEF0;
    frame_w[2] = 32'h0F0F0F11;
    pulse_reload();
    wr_cyc.delete();
    send_frame(16'd3, 8'h1E, 1'b0);
    chk_status("n3", 1'b1, 1'b0, 1'b0, 16'd3);
    chk("n3_wr_count", 64'(wr_cyc.size()), 64'd3);
    if (wr_cyc.size() == 3) begin
      chk("n3_gap1", 64'(wr_cyc[1] - wr_cyc[0]), 64'd4);
      chk("n3_gap2", 64'(wr_cyc[2] - wr_cyc[1]), 64'd4);
    end
    chk("n3_last_wr_in_csum", 64'(last_wr_state), 64'(ST_CSUM));

    // Same N=3 frame with byte_valid randomly gated.
    pulse_reload();
    wr_cyc.delete();
    send_frame(16'd3, 8'h1E, 1'b1);
    chk_status("n3_gated", 1'b1, 1'b0, 1'b0, 16'd3);
    chk("n3_gated_wr_count", 64'(wr_cyc.size()), 64'd3);

    // Abort after 6 data bytes, then a full N=1 frame.
    pulse_reload();
    exp_q.push_back({32'h0, 32'h20080005});
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h09);
    @(negedge clk);
    chk("part_words", 64'(words_loaded), 64'd1);
    @(posedge clk);
    #1;
    pulse_reload();
    @(negedge clk);
    chk("abort_words", 64'(words_loaded), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'(ST_HDR_HI));
    @(posedge clk);
    #1;
    frame_w[0] = 32'hDEADBEEF;
    wr_cyc.delete();
    send_frame(16'd1, 8'h22, 1'b0);
    chk_status("n1", 1'b1, 1'b0, 1'b0, 16'd1);
    chk("n1_wr_count", 64'(wr_cyc.size()), 64'd1);

    // Asynchronous reset in the middle of DATA.
    pulse_reload();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h08);
    #3 rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    chk("post_rst_pending", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
